uart_prog_loader: RTL and testbench

- Programming front-end upstream of the instruction and data memories: receives a framed image over a UART RX line (8N1) and writes 32-bit words into either memory through a shared write port.
- Drives `cpu_en` low while an image is loading, so the top level can switch between UART mode and run mode.
- Emits a one-cycle `prog_done` pulse that the top uses to restart the CPU at the text base.

---
 rtl/uart_prog_loader.sv | 199 +++++++++++++++++++
 tb/tb_uart_prog_loader.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_prog_loader.sv
// UART (8N1) image loader: frames HDR/LEN/words into 32-bit writes to instruction or data memory.
// Latency: write strobe 1 clk after the stop-bit sample of each word's 4th byte.
// Backpressure: none; the memory port accepts every strobe. UART_LOADER_CHECKSUM_EN adds a trailing XOR check byte.
module uart_prog_loader #(
    parameter int CLKS_PER_BIT = 16,
    parameter int ADDR_W       = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              uart_rx,
    input  logic              load_req,
    output logic              cpu_en,
    output logic              mem_we,
    output logic              mem_sel,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              prog_done,
    output logic              err
);
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    localparam logic [1:0] R_IDLE  = 2'd0;
    localparam logic [1:0] R_START = 2'd1;
    localparam logic [1:0] R_DATA  = 2'd2;
    localparam logic [1:0] R_STOP  = 2'd3;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_HDR  = 3'd1;
    localparam logic [2:0] S_LHI  = 3'd2;
    localparam logic [2:0] S_LLO  = 3'd3;
    localparam logic [2:0] S_DATA = 3'd4;
`ifdef UART_LOADER_CHECKSUM_EN
    localparam logic [2:0] S_CHK  = 3'd5;
`endif
    localparam logic [2:0] S_DONE = 3'd6;
    localparam logic [2:0] S_ERR  = 3'd7;

    logic          rx_s1, rx_s2, rx_d;
    logic [1:0]    rx_st;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_shift;
    logic          byte_done, frame_bad;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_d     <= 1'b1;
            rx_st    <= R_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            rx_s1 <= uart_rx;
            rx_s2 <= rx_s1;
            rx_d  <= rx_s2;
            case (rx_st)
                R_IDLE: if (rx_d && !rx_s2) begin
                    rx_st  <= R_START;
                    rx_cnt <= '0;
                end
                R_START: if (rx_cnt == HALF_LAST) begin
                    // line back high at mid start bit means a glitch, not a frame
                    rx_cnt <= '0;
                    rx_bit <= '0;
                    rx_st  <= rx_s2 ? R_IDLE : R_DATA;
                end else begin
                    rx_cnt <= rx_cnt + 1'b1;
                end
                R_DATA: if (rx_cnt == BIT_LAST) begin
                    rx_cnt   <= '0;
                    rx_shift <= {rx_s2, rx_shift[7:1]};
                    rx_bit   <= rx_bit + 1'b1;
                    if (rx_bit == 3'd7) rx_st <= R_STOP;
                end else begin
                    rx_cnt <= rx_cnt + 1'b1;
                end
                default: if (rx_cnt == BIT_LAST) begin
                    rx_cnt <= '0;
                    rx_st  <= R_IDLE;
                end else begin
                    rx_cnt <= rx_cnt + 1'b1;
                end
            endcase
        end
    end

    // Stop-sample cycle: the loader registers the byte here, so it is visible one clk later.
    assign byte_done = (rx_st == R_STOP) && (rx_cnt == BIT_LAST) && rx_s2;
    assign frame_bad = (rx_st == R_STOP) && (rx_cnt == BIT_LAST) && !rx_s2;

    logic [2:0]  state, st_eff;
    logic [7:0]  len_hi;
    logic [15:0] len, len_full;
    logic [1:0]  idx;
    logic        take, hdr_ok, len_over, last_word;
`ifdef UART_LOADER_CHECKSUM_EN
    logic [7:0]  csum;
`endif

    // An accepted load_req lets a byte finishing in the same cycle land in WAIT_HDR.
    assign take      = ((state == S_IDLE) || (state == S_DONE) || (state == S_ERR)) && load_req;
    assign st_eff    = take ? S_HDR : state;
    assign hdr_ok    = (rx_shift == 8'h49) || (rx_shift == 8'h44);
    assign len_full  = {len_hi, rx_shift};
    assign len_over  = 32'(len_full) > (32'd1 << ADDR_W);
    assign last_word = 32'(mem_addr) == (32'(len) - 32'd1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            mem_we    <= 1'b0;
            mem_sel   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            len_hi    <= '0;
            len       <= '0;
            idx       <= '0;
`ifdef UART_LOADER_CHECKSUM_EN
            csum      <= '0;
`endif
        end else begin
            mem_we <= 1'b0;
            state  <= st_eff;
            case (st_eff)
                S_DONE: state <= S_IDLE;
                S_HDR: begin
                    if (frame_bad) state <= S_ERR;
                    else if (byte_done) begin
                        state   <= hdr_ok ? S_LHI : S_ERR;
                        mem_sel <= (rx_shift == 8'h44);
                    end
                end
                S_LHI: begin
                    if (frame_bad) state <= S_ERR;
                    else if (byte_done) begin
                        len_hi <= rx_shift;
                        state  <= S_LLO;
                    end
                end
                S_LLO: begin
                    if (frame_bad) state <= S_ERR;
                    else if (byte_done) begin
                        if (len_full == 16'd0) state <= S_DONE;
                        else if (len_over)     state <= S_ERR;
                        else begin
                            state    <= S_DATA;
                            len      <= len_full;
                            mem_addr <= '0;
                            idx      <= '0;
`ifdef UART_LOADER_CHECKSUM_EN
                            csum     <= '0;
`endif
                        end
                    end
                end
                S_DATA: begin
                    // Leave DATA on the strobe cycle so mem_we never shows outside it.
                    if (mem_we) begin
                        if (last_word) begin
`ifdef UART_LOADER_CHECKSUM_EN
                            state <= S_CHK;
`else
                            state <= S_DONE;
`endif
                        end else begin
                            mem_addr <= mem_addr + 1'b1;
                        end
                    end else if (frame_bad) begin
                        state <= S_ERR;
                    end else if (byte_done) begin
                        mem_wdata <= {rx_shift, mem_wdata[31:8]};
                        idx       <= idx + 1'b1;
                        if (idx == 2'd3) mem_we <= 1'b1;
`ifdef UART_LOADER_CHECKSUM_EN
                        csum      <= csum ^ rx_shift;
`endif
                    end
                end
`ifdef UART_LOADER_CHECKSUM_EN
                S_CHK: begin
                    if (frame_bad) state <= S_ERR;
                    else if (byte_done) state <= (rx_shift == csum) ? S_DONE : S_ERR;
                end
`endif
                default: ;
            endcase
        end
    end

    assign cpu_en    = (state == S_IDLE) || (state == S_DONE);
    assign busy      = !((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));
    assign prog_done = (state == S_DONE);
    assign err       = (state == S_ERR);
endmodule

// File: tb/tb_uart_prog_loader.sv
// Scoreboard bench for uart_prog_loader: directed UART frames, expected writes/done events queued and checked by a monitor.
`timescale 1ns/1ps
module tb_uart_prog_loader;
    localparam int CPB = 16;
    localparam int AW  = 14;

    logic          clk = 1'b0;
    logic          rst;
    logic          uart_rx;
    logic          load_req;
    logic          cpu_en, mem_we, mem_sel, busy, prog_done, err;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        bit          is_done;
        bit          sel;
        int          addr;
        logic [31:0] data;
    } ev_t;
    ev_t exp_q[$];

    uart_prog_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .uart_rx(uart_rx), .load_req(load_req),
        .cpu_en(cpu_en), .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .busy(busy), .prog_done(prog_done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic push_wr(input bit sel, input int addr, input logic [31:0] data);
        ev_t e;
        e.is_done = 1'b0; e.sel = sel; e.addr = addr; e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic push_done();
        ev_t e;
        e.is_done = 1'b1; e.sel = 1'b0; e.addr = 0; e.data = 32'h0;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        ev_t e;
        if (rst && (mem_we || prog_done)) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_event: we=%b done=%b addr=%h data=%h, none expected",
                         mem_we, prog_done, mem_addr, mem_wdata);
            end else begin
                e = exp_q.pop_front();
                check("event_kind", {31'd0, prog_done}, {31'd0, e.is_done});
                if (mem_we) begin
                    check("wr_sel", {31'd0, mem_sel}, {31'd0, e.sel});
                    check("wr_addr", 32'(mem_addr), e.addr);
                    check("wr_data", mem_wdata, e.data);
                    check("wr_cpu_en", {31'd0, cpu_en}, 32'd0);
                end else begin
                    check("done_cpu_en", {31'd0, cpu_en}, 32'd1);
                    check("done_err", {31'd0, err}, 32'd0);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit stop_ok = 1'b1);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = stop_ok;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic pulse_load();
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 4000) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            n_chk++;
            n_fail++;
            $display("FAIL wait_idle: busy still %b after %0d cycles, required 0", busy, n);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cpu_en"}, {31'd0, cpu_en}, 32'd1);
        check({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
        check({tag, "_mem_sel"}, {31'd0, mem_sel}, 32'd0);
        check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_prog_done"}, {31'd0, prog_done}, 32'd0);
        check({tag, "_err"}, {31'd0, err}, 32'd0);
    endtask

    initial begin
        uart_rx  = 1'b1;
        load_req = 1'b0;
        rst      = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // Basic instruction load; load_req held high mid-frame must be ignored.
        pulse_load();
        check("ld_cpu_en", {31'd0, cpu_en}, 32'd0);
        check("ld_busy", {31'd0, busy}, 32'd1);
        push_wr(1'b0, 0, 32'h12345678);
        push_wr(1'b0, 1, 32'hDEADBEEF);
        push_done();
        send_byte(8'h49);
        load_req = 1'b1;
        send_byte(8'h00);
        send_byte(8'h02);
        send_word(32'h12345678);
        load_req = 1'b0;
        send_word(32'hDEADBEEF);
`ifdef UART_LOADER_CHECKSUM_EN
        send_byte(8'h2A);
`endif
        wait_idle();
        check("basic_q_empty", exp_q.size(), 32'd0);
        check("basic_cpu_en", {31'd0, cpu_en}, 32'd1);
        check("basic_err", {31'd0, err}, 32'd0);

        // Zero-length data image
        pulse_load();
        push_done();
        send_byte(8'h44);
        send_byte(8'h00);
        send_byte(8'h00);
        wait_idle();
        check("zero_q_empty", exp_q.size(), 32'd0);
        check("zero_err", {31'd0, err}, 32'd0);

        // Bad header, then recovery with a 1-word data frame
        pulse_load();
        send_byte(8'h55);
        check("badhdr_err", {31'd0, err}, 32'd1);
        check("badhdr_cpu_en", {31'd0, cpu_en}, 32'd0);
        check("badhdr_busy", {31'd0, busy}, 32'd0);
        pulse_load();
        check("recover_err_clr", {31'd0, err}, 32'd0);
        push_wr(1'b1, 0, 32'hDDCCBBAA);
        push_done();
        send_byte(8'h44);
        send_byte(8'h00);
        send_byte(8'h01);
        send_word(32'hDDCCBBAA);
`ifdef UART_LOADER_CHECKSUM_EN
        send_byte(8'h00);
`endif
        wait_idle();
        check("recover_q_empty", exp_q.size(), 32'd0);
        check("recover_err", {31'd0, err}, 32'd0);

        // Framing error on LEN_HI
        pulse_load();
        send_byte(8'h49);
        send_byte(8'h00, 1'b0);
        check("framing_err", {31'd0, err}, 32'd1);

        // Short low glitch must not produce a byte
        pulse_load();
        uart_rx = 1'b0;
        repeat (CPB / 4) @(negedge clk);
        uart_rx = 1'b1;
        repeat (12 * CPB) @(negedge clk);
        check("glitch_err", {31'd0, err}, 32'd0);
        check("glitch_busy", {31'd0, busy}, 32'd1);
        push_wr(1'b0, 0, 32'hCAFEF00D);
        push_done();
        send_byte(8'h49);
        send_byte(8'h00);
        send_byte(8'h01);
        send_word(32'hCAFEF00D);
`ifdef UART_LOADER_CHECKSUM_EN
        send_byte(8'hC9);
`endif
        wait_idle();
        check("glitch_q_empty", exp_q.size(), 32'd0);

        // Length limits
        pulse_load();
        send_byte(8'h49); send_byte(8'hFF); send_byte(8'hFF);
        check("len_ffff_err", {31'd0, err}, 32'd1);
        pulse_load();
        send_byte(8'h49); send_byte(8'h40); send_byte(8'h01);
        check("len_4001_err", {31'd0, err}, 32'd1);
        pulse_load();
        send_byte(8'h49); send_byte(8'h40); send_byte(8'h00);
        check("len_4000_err", {31'd0, err}, 32'd0);
        check("len_4000_busy", {31'd0, busy}, 32'd1);
        check("len_4000_addr", 32'(mem_addr), 32'd0);

        // Reset abort after 2 words of a 4-word frame
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        pulse_load();
        push_wr(1'b1, 0, 32'h11223344);
        push_wr(1'b1, 1, 32'h55667788);
        send_byte(8'h44); send_byte(8'h00); send_byte(8'h04);
        send_word(32'h11223344);
        send_word(32'h55667788);
        check("abort_q_empty", exp_q.size(), 32'd0);
        check("abort_pre_addr", 32'(mem_addr), 32'd2);
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("abort");
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

`ifdef UART_LOADER_CHECKSUM_EN
        // Checksum mismatch: both words still written, then ERR
        pulse_load();
        push_wr(1'b0, 0, 32'h12345678);
        push_wr(1'b0, 1, 32'hDEADBEEF);
        send_byte(8'h49); send_byte(8'h00); send_byte(8'h02);
        send_word(32'h12345678);
        send_word(32'hDEADBEEF);
        send_byte(8'h01);
        check("csum_bad_err", {31'd0, err}, 32'd1);
        check("csum_bad_q_empty", exp_q.size(), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
